// File: rtl/intr_arbiter.sv
// Interrupt sequencer: latches source edges, masks, arbitrates, and tracks one trap until mret.
// Define INTR_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module intr_arbiter #(
  parameter int                  NSRC      = 4,
  parameter int                  IDW       = $clog2(NSRC),
  parameter logic [5*NSRC-1:0]   CAUSE_MAP = {5'd17, 5'd16, 5'd7, 5'd11}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic [NSRC-1:0] src_en,
  input  logic            glb_en,
  input  logic            irq_ack,
  input  logic            irq_done,
  output logic            irq_req,
  output logic [IDW-1:0]  irq_id,
  output logic [31:0]     irq_cause,
  output logic [NSRC-1:0] pend,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERV
  } state_t;

  state_t          state;
  logic [NSRC-1:0] src_prev;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [4:0]      win_code;
  logic            take_ack;

  assign rise     = src_irq & ~src_prev;
  assign elig     = pend & src_en & {NSRC{glb_en}};
  assign take_ack = (state == ST_REQ) && irq_ack;

  // NOTE: every signal driven in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (take_ack && (irq_id == IDW'(i))) clr[i] = 1'b1;
    end
  end

`ifdef INTR_RR_EN
  logic [IDW-1:0]    rr_ptr;
  logic [2*NSRC-1:0] elig_rot;
  logic [IDW:0]      rr_sum;

  // Rotate so the search always starts at bit 0, then map the offset back to a source index.
  assign elig_rot = {elig, elig} >> rr_ptr;

  always_comb begin
    win_vld = 1'b0;
    rr_sum  = '0;
    for (int off = NSRC - 1; off >= 0; off--) begin
      if (elig_rot[off]) begin
        win_vld = 1'b1;
        rr_sum  = {1'b0, rr_ptr} + (IDW+1)'(off);
      end
    end
    if (rr_sum >= (IDW+1)'(NSRC)) win_id = IDW'(rr_sum - (IDW+1)'(NSRC));
    else                          win_id = rr_sum[IDW-1:0];
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_id  = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    win_code = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win_id == IDW'(i)) win_code = CAUSE_MAP[5*i +: 5];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      src_prev  <= '0;
      pend      <= '0;
      irq_req   <= 1'b0;
      irq_id    <= '0;
      irq_cause <= '0;
      busy      <= 1'b0;
`ifdef INTR_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      src_prev <= src_irq;
      // A fresh edge on the bit being acked wins over the clear.
      pend     <= (pend & ~clr) | rise;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state     <= ST_REQ;
            irq_req   <= 1'b1;
            busy      <= 1'b1;
            irq_id    <= win_id;
            irq_cause <= {1'b1, 26'd0, win_code};
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state   <= ST_SERV;
            irq_req <= 1'b0;
`ifdef INTR_RR_EN
            rr_ptr  <= (irq_id == IDW'(NSRC - 1)) ? '0 : irq_id + 1'b1;
`endif
          end else if (!glb_en || !src_en[irq_id]) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_SERV: begin
          if (irq_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios plus random traffic against a transaction-level model;
// request events go through a scoreboard queue popped by an independent monitor.
module tb_intr_arbiter;
  localparam int NSRC = 4;
  localparam int IDW  = 2;

  typedef enum {M_IDLE, M_REQ, M_SERV} mmode_t;
  typedef struct {
    int id;
    int cyc;
  } req_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src_irq;
  logic [NSRC-1:0] src_en;
  logic            glb_en;
  logic            irq_ack;
  logic            irq_done;
  logic            irq_req;
  logic [IDW-1:0]  irq_id;
  logic [31:0]     irq_cause;
  logic [NSRC-1:0] pend;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  mmode_t          m_mode;
  logic [NSRC-1:0] m_pend;
  logic [NSRC-1:0] m_prev;
  int              m_id;
  int              m_ptr;
  req_t            sbq[$];
  logic            mon_prev_req;
  int              cause_tbl[NSRC] = '{11, 7, 16, 17};

  intr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .src_en    (src_en),
    .glb_en    (glb_en),
    .irq_ack   (irq_ack),
    .irq_done  (irq_done),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_cause (irq_cause),
    .pend      (pend),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] cause_of(int id);
    return 32'h8000_0000 | 32'(cause_tbl[id]);
  endfunction

  // Winner by the arbitration rule; -1 when nothing is eligible.
  function automatic int pick(logic [NSRC-1:0] e);
`ifdef INTR_RR_EN
    for (int k = 0; k < NSRC; k++) begin
      int j;
      j = (m_ptr + k) % NSRC;
      if (e[j]) return j;
    end
`else
    for (int k = 0; k < NSRC; k++) begin
      if (e[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pend = '0;
    m_prev = '0;
    m_id   = 0;
    m_ptr  = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    logic [NSRC-1:0] rising, elig, clear;
    int w;
    rising = src_irq & ~m_prev;
    elig   = m_pend & src_en & {NSRC{glb_en}};
    clear  = '0;
    cycle++;
    case (m_mode)
      M_IDLE: begin
        w = pick(elig);
        if (w >= 0) begin
          m_mode = M_REQ;
          m_id   = w;
          sbq.push_back('{id: w, cyc: cycle});
        end
      end
      M_REQ: begin
        if (irq_ack) begin
          clear[m_id] = 1'b1;
          m_mode      = M_SERV;
          m_ptr       = (m_id + 1) % NSRC;
        end else if (!glb_en || !src_en[m_id]) begin
          m_mode = M_IDLE;
        end
      end
      M_SERV: if (irq_done) m_mode = M_IDLE;
      default: ;
    endcase
    m_pend = (m_pend & ~clear) | rising;
    m_prev = src_irq;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
    end
  endtask

  task automatic ack_done();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    cyc(1);
    irq_done = 1'b0;
  endtask

  task automatic wait_req(output int id);
    int n = 0;
    while (m_mode != M_REQ && n < 20) begin
      cyc(1);
      n++;
    end
    if (m_mode != M_REQ) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got no request within 20 cycles, expected one");
      id = -1;
    end else begin
      id = int'(irq_id);
    end
  endtask

  // Monitor: per-cycle state against the model, request events against the scoreboard.
  initial begin
    mon_prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_req = 1'b0;
      end else begin
        check("irq_req", irq_req, m_mode == M_REQ);
        check("busy", busy, m_mode != M_IDLE);
        check("pend", pend, m_pend);
        if (m_mode != M_IDLE) begin
          check("irq_id", irq_id, m_id);
          check("irq_cause", irq_cause, cause_of(m_id));
        end
        if (irq_req && !mon_prev_req) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got request id %0d, expected none", irq_id);
          end else begin
            req_t r;
            r = sbq.pop_front();
            check("sb_id", irq_id, r.id);
            check("sb_cause", irq_cause, cause_of(r.id));
            check("sb_cycle", cycle, r.cyc);
          end
        end
        mon_prev_req = irq_req;
      end
    end
  end

  initial begin
    int id;
    int exp_order[5];
    rst      = 1'b1;
    src_irq  = '0;
    src_en   = 4'hF;
    glb_en   = 1'b1;
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    model_reset();
    #2;
    check("rst_req", irq_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend, 0);
    check("rst_id", irq_id, 0);
    check("rst_cause", irq_cause, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Single source pulse.
    src_irq[2] = 1'b1;
    cyc(1);
    src_irq[2] = 1'b0;
    check("t1_pend", pend, 4'b0100);
    check("t1_req_early", irq_req, 0);
    cyc(1);
    check("t1_req", irq_req, 1);
    check("t1_id", irq_id, 2);
    check("t1_cause", irq_cause, 32'h8000_0010);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check("t1_ack_pend", pend, 0);
    check("t1_ack_req", irq_req, 0);
    check("t1_ack_busy", busy, 1);
    irq_done = 1'b1;
    cyc(1);
    irq_done = 1'b0;
    check("t1_done_busy", busy, 0);

    // Simultaneous sources 3 and 1.
    src_irq = 4'b1010;
    cyc(1);
    src_irq = '0;
    cyc(1);
    check("t2_req1", irq_req, 1);
`ifndef INTR_RR_EN
    check("t2_id1", irq_id, 1);
    check("t2_cause1", irq_cause, 32'h8000_0007);
`endif
    ack_done();
    check("t2_gap", irq_req, 0);
    cyc(1);
    check("t2_req2", irq_req, 1);
`ifndef INTR_RR_EN
    check("t2_id2", irq_id, 3);
    check("t2_cause2", irq_cause, 32'h8000_0011);
`endif
    ack_done();

    // Global mask holds the request back while pend latches.
    glb_en     = 1'b0;
    src_irq[0] = 1'b1;
    cyc(1);
    src_irq[0] = 1'b0;
    cyc(3);
    check("t3_pend", pend, 4'b0001);
    check("t3_masked", irq_req, 0);
    glb_en = 1'b1;
    cyc(1);
    check("t3_req", irq_req, 1);
    check("t3_id", irq_id, 0);
    check("t3_cause", irq_cause, 32'h8000_000B);
    ack_done();

    // Withdraw on source disable, return on re-enable.
    src_irq[2] = 1'b1;
    cyc(1);
    src_irq[2] = 1'b0;
    cyc(1);
    check("t4_req", irq_req, 1);
    src_en = 4'b1011;
    cyc(1);
    check("t4_withdrawn", irq_req, 0);
    check("t4_pend_kept", pend, 4'b0100);
    src_en = 4'hF;
    cyc(1);
    check("t4_back", irq_req, 1);
    check("t4_id", irq_id, 2);
    ack_done();

    // A level held high across ack does not re-pend.
    src_irq[1] = 1'b1;
    cyc(2);
    ack_done();
    cyc(3);
    check("t5_no_repend", pend, 0);
    check("t5_no_req", irq_req, 0);
    src_irq[1] = 1'b0;
    cyc(1);

    // Asynchronous reset in SERV, then a stray done.
    src_irq[3] = 1'b1;
    cyc(1);
    src_irq[3] = 1'b0;
    cyc(1);
    irq_ack    = 1'b1;
    src_irq[0] = 1'b1;
    cyc(1);
    irq_ack    = 1'b0;
    src_irq[0] = 1'b0;
    check("t6_serv_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_req", irq_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pend", pend, 0);
    check("t6_rst_id", irq_id, 0);
    model_reset();
    cyc(1);
    rst      = 1'b0;
    irq_done = 1'b1;
    cyc(1);
    irq_done = 1'b0;
    check("t6_stray_busy", busy, 0);
    check("t6_stray_req", irq_req, 0);
    cyc(1);

    // All four pending, each re-pulsed after its ack.
`ifdef INTR_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    src_irq = 4'hF;
    cyc(1);
    src_irq = '0;
    for (int k = 0; k < 5; k++) begin
      wait_req(id);
      check($sformatf("t7_order%0d", k), id, exp_order[k]);
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      if (id >= 0) src_irq[id] = 1'b1;
      cyc(1);
      src_irq  = '0;
      irq_done = 1'b1;
      cyc(1);
      irq_done = 1'b0;
    end

    // Random traffic, including stray ack/done and enable churn.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NSRC; b++) begin
        if ($urandom_range(7) == 0) src_irq[b] = ~src_irq[b];
      end
      src_en   = ($urandom_range(9) == 0) ? 4'($urandom) : 4'hF;
      glb_en   = ($urandom_range(11) != 0);
      irq_ack  = (m_mode == M_REQ && $urandom_range(1) == 1) || ($urandom_range(15) == 0);
      irq_done = (m_mode == M_SERV && $urandom_range(2) == 0) || ($urandom_range(15) == 0);
      cyc(1);
    end

    // Drain.
    src_irq = '0;
    src_en  = 4'hF;
    glb_en  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      irq_ack  = (m_mode == M_REQ);
      irq_done = (m_mode == M_SERV);
      cyc(1);
    end
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    check("sb_drain", sbq.size(), 0);
    check("final_pend", pend, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
